// File: rtl/alu_result_stage.sv
// ALU result select stage: captures the op_sel-chosen unit result into a 2-entry skid buffer.
// Optional zero flag (out_zero) enabled with macro ALU_ZERO_FLAG_EN.
module alu_result_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op_sel,
    input  logic [WIDTH-1:0] and_res,
    input  logic [WIDTH-1:0] or_res,
    input  logic [WIDTH-1:0] xor_res,
    input  logic [WIDTH-1:0] add_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    // Each stored entry carries its zero flag in the MSB when the flag is enabled.
`ifdef ALU_ZERO_FLAG_EN
    localparam int unsigned EW = WIDTH + 1;
`else
    localparam int unsigned EW = WIDTH;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [EW-1:0]    main_q;
    logic [EW-1:0]    skid_q;
    logic [WIDTH-1:0] res_d;
    logic [EW-1:0]    entry_d;
    logic             in_fire;
    logic             out_fire;

    always_comb begin
        res_d = '0;
        case (op_sel)
            2'b00:   res_d = and_res;
            2'b01:   res_d = or_res;
            2'b10:   res_d = xor_res;
            default: res_d = add_res;
        endcase
    end

`ifdef ALU_ZERO_FLAG_EN
    assign entry_d  = {(res_d == '0), res_d};
    assign out_zero = main_q[WIDTH];
`else
    assign entry_d  = res_d;
`endif

    assign in_fire    = in_valid && in_ready_q;
    assign out_fire   = out_valid_q && out_ready;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = main_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_q      <= entry_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    case ({in_fire, out_fire})
                        2'b10: begin
                            skid_q     <= entry_d;
                            in_ready_q <= 1'b0;
                            state_q    <= TWO;
                        end
                        2'b01: begin
                            out_valid_q <= 1'b0;
                            state_q     <= EMPTY;
                        end
                        2'b11: main_q <= entry_d;
                        default: ;
                    endcase
                end
                TWO: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage; checks out_zero when ALU_ZERO_FLAG_EN is defined.
module tb_alu_result_stage;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op_sel;
    logic [W-1:0] and_res, or_res, xor_res, add_res;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
`ifdef ALU_ZERO_FLAG_EN
    logic         out_zero;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [W-1:0] sb[$];
    logic         stall_prev = 1'b0;
    logic [W-1:0] stall_val;
    logic [W-1:0] exp_v;

    alu_result_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_sel     (op_sel),
        .and_res    (and_res),
        .or_res     (or_res),
        .xor_res    (xor_res),
        .add_res    (add_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .out_zero   (out_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] d);
        case (op)
            2'b00:   return a;
            2'b01:   return o;
            2'b10:   return x;
            default: return d;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] o, input logic [W-1:0] x, input logic [W-1:0] d);
        in_valid = v;
        op_sel   = op;
        and_res  = a;
        or_res   = o;
        xor_res  = x;
        add_res  = d;
    endtask

    // Reference occupancy and ordering; handshakes are observed mid-cycle, ahead of the edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            check_eq("in_ready", in_ready, sb.size() < 2);
            check_eq("out_valid", out_valid, sb.size() != 0);
            if (stall_prev) check_eq("stall_stable", out_result, stall_val);
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_v = sb.pop_front();
                check_eq("out_result", out_result, exp_v);
`ifdef ALU_ZERO_FLAG_EN
                check_eq("out_zero", out_zero, exp_v == '0);
`endif
            end
            if (in_valid && in_ready)
                sb.push_back(pick(op_sel, and_res, or_res, xor_res, add_res));
            stall_prev = out_valid && !out_ready;
            stall_val  = out_result;
        end
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        tick();
        tick();
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_result", out_result, '0);
`ifdef ALU_ZERO_FLAG_EN
        check_eq("rst_out_zero", out_zero, 1'b0);
`endif
        rst = 1'b0;

        // Single OR result, one-cycle latency, then empty
        out_ready = 1'b1;
        drive(1'b1, 2'b01, 32'h0F0F0F0F, 32'hFFFF00FF, 32'h1, 32'h2);
        tick();
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        check_eq("lat_out_valid", out_valid, 1'b1);
        check_eq("lat_out_result", out_result, 32'hFFFF00FF);
        tick();
        check_eq("lat_empty", out_valid, 1'b0);

        // Fill to TWO, then drain
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 32'h1, 32'h2, 32'h3, 32'h00000005);
        tick();
        drive(1'b1, 2'b10, 32'h1, 32'h2, 32'h000000A0, 32'h4);
        tick();
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        check_eq("full_in_ready", in_ready, 1'b0);
        check_eq("full_head", out_result, 32'h5);
        out_ready = 1'b1;
        tick();
        check_eq("drain_second", out_result, 32'hA0);
        check_eq("drain_in_ready", in_ready, 1'b1);
        tick();
        check_eq("drain_empty", out_valid, 1'b0);

        // Back-to-back stream, no bubbles
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'b11, '1, '1, '1, W'(i + 1));
            tick();
            check_eq("stream_valid", out_valid, 1'b1);
            check_eq("stream_data", out_result, W'(i + 1));
            check_eq("stream_in_ready", in_ready, 1'b1);
        end
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        tick();
        check_eq("stream_done", out_valid, 1'b0);

`ifdef ALU_ZERO_FLAG_EN
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h00000000, 32'h1, 32'h1, 32'h1);
        tick();
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        check_eq("zf_and_zero", out_zero, 1'b1);
        out_ready = 1'b1;
        tick();
        drive(1'b1, 2'b01, 32'h0, 32'h80000000, 32'h0, 32'h0);
        tick();
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        check_eq("zf_or_nonzero", out_zero, 1'b0);
        tick();
`endif

        // Reset while full with a competing input
        out_ready = 1'b0;
        drive(1'b1, 2'b11, '0, '0, '0, 32'h11);
        tick();
        drive(1'b1, 2'b11, '0, '0, '0, 32'h22);
        tick();
        check_eq("pre_rst_full", in_ready, 1'b0);
        rst = 1'b1;
        drive(1'b1, 2'b11, '0, '0, '0, 32'h33);
        tick();
        rst = 1'b0;
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        check_eq("mid_rst_out_valid", out_valid, 1'b0);
        check_eq("mid_rst_in_ready", in_ready, 1'b1);
        check_eq("mid_rst_out_result", out_result, '0);
`ifdef ALU_ZERO_FLAG_EN
        check_eq("mid_rst_out_zero", out_zero, 1'b0);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("post_rst_no_stale", out_valid, 1'b0);
        end

        // Random valid/ready traffic
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? '0 : W'($urandom),
                  W'($urandom), W'($urandom),
                  ($urandom_range(0, 7) == 0) ? '0 : W'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 8 && out_valid; i++) tick();
        tick();
        check_eq("final_drained", out_valid, 1'b0);
        check_eq("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
